// File: rtl/des_block_loader.sv
// Byte-serial to 64-bit block assembler feeding the DES initial permutation.
// Packs 8 bytes MSB-first into [0:63] and buffers up to BUF_DEPTH complete blocks.
module des_block_loader #(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [0:63] block_out,
  output logic        block_valid,
  input  logic        block_ready,
  output logic [2:0]  byte_cnt,
  output logic [1:0]  blocks_held
);

  localparam logic [1:0] DEPTH_L  = 2'(BUF_DEPTH);
  localparam bit         PINGPONG = (BUF_DEPTH == 2);

  logic [0:63] r_buf [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [2:0]  r_byte_cnt;
  logic [1:0]  r_blocks_held;
  logic        r_block_valid;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_complete;
  logic        w_pop;
  logic [1:0]  w_held_nxt;

  // Depends only on registered occupancy plus rst/flush: no path from block_ready or in_valid.
  assign w_in_ready = !rst && !flush && (r_blocks_held < DEPTH_L);
  assign w_accept   = in_valid && w_in_ready;
  assign w_complete = w_accept && (r_byte_cnt == 3'd7);
  assign w_pop      = r_block_valid && block_ready;

  always_comb begin
    w_held_nxt = r_blocks_held;
    if (w_complete && !w_pop) begin
      w_held_nxt = r_blocks_held + 2'd1;
    end else if (!w_complete && w_pop) begin
      w_held_nxt = r_blocks_held - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf[0]      <= '0;
      r_buf[1]      <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_byte_cnt    <= 3'd0;
      r_blocks_held <= 2'd0;
      r_block_valid <= 1'b0;
    end else begin
      // Byte k lands in bits 8k..8k+7 with its MSB at bit 8k.
      if (w_accept) begin
        r_buf[r_wr_ptr][{r_byte_cnt, 3'b000} +: 8] <= in_byte;
      end
      if (flush) begin
        r_byte_cnt <= 3'd0;
      end else if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 3'd1;
      end
      if (w_complete && PINGPONG) begin
        r_wr_ptr <= !r_wr_ptr;
      end
      if (w_pop && PINGPONG) begin
        r_rd_ptr <= !r_rd_ptr;
      end
      r_blocks_held <= w_held_nxt;
      r_block_valid <= (w_held_nxt != 2'd0);
    end
  end

  assign in_ready    = w_in_ready;
  assign block_out   = r_buf[r_rd_ptr];
  assign block_valid = r_block_valid;
  assign byte_cnt    = r_byte_cnt;
  assign blocks_held = r_blocks_held;

endmodule
